uart_rx: RTL and testbench

- Hard-coded 8-bit UART receiver; counterpart to the team's UART transmitter.
- Oversamples the serial line at 16 samples per bit, paced by a 1-clk sample_trigger pulse from the shared baud-tick generator.
- Recovers one byte per frame and presents it with a 1-clk valid pulse to downstream logic (FIFO, command parser).

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default oversampling and receiver FSM states.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS      = 8;
    localparam int unsigned UART_SAMPLES_PER_BIT = 16;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-stage flip-flop synchronizer for an asynchronous single-bit input.
// Resets to 1 so an idle (mark) serial line never looks like a start bit.
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8-bit MSB-first UART receiver, oversampled SAMPLES_PER_BIT times per bit.
// Optional stop-bit check enabled by defining UART_RX_STOP_CHECK_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_BIT = UART_SAMPLES_PER_BIT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sample_trigger,
    input  logic                      serial_data,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      framing_error,
    output logic                      busy
);

    localparam int unsigned CntW = $clog2(SAMPLES_PER_BIT);
    localparam int unsigned BitW = $clog2(UART_DATA_BITS);

    localparam logic [CntW-1:0] HalfM1  = CntW'(SAMPLES_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullM1  = CntW'(SAMPLES_PER_BIT - 1);
    localparam logic [BitW-1:0] LastBit = BitW'(UART_DATA_BITS - 1);

    logic line_s;
    logic stop_ok;

    uart_rx_state_t            state_q, state_d;
    logic [CntW-1:0]           sample_cnt_q, sample_cnt_d;
    logic [BitW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      busy_q, busy_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(serial_data),
        .q_o(line_s)
    );

`ifdef UART_RX_STOP_CHECK_EN
    assign stop_ok = line_s;
`else
    // Stop bit ignored: every frame completes; err_q stays constant 0.
    assign stop_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        data_d       = data_q;
        busy_d       = busy_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;

        if (sample_trigger) begin
            unique case (state_q)
                // Re-arm only after the line has been seen high.
                WAIT_IDLE: begin
                    if (line_s) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (!line_s) begin
                        state_d      = START;
                        sample_cnt_d = '0;
                        busy_d       = 1'b1;
                    end
                end
                START: begin
                    if (sample_cnt_q == HalfM1) begin
                        sample_cnt_d = '0;
                        if (line_s) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (sample_cnt_q == FullM1) begin
                        sample_cnt_d = '0;
                        shreg_d      = {shreg_q[UART_DATA_BITS-2:0], line_s};
                        if (bit_cnt_q == LastBit) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (sample_cnt_q == FullM1) begin
                        sample_cnt_d = '0;
                        state_d      = WAIT_IDLE;
                        busy_d       = 1'b0;
                        if (stop_ok) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = WAIT_IDLE;
                end
            endcase
        end
    end

    assign data          = data_q;
    assign valid         = valid_q;
    assign framing_error = err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; expectations follow UART_RX_STOP_CHECK_EN.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BitClks = 64; // 16 triggers per bit, one trigger every 4 clks

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_data;
    logic       sample_trigger;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       busy;
    logic [1:0] div_q = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ferr   = 0;
    int n_both   = 0;
    int n_long   = 0;
    logic valid_prev = 1'b0;
    logic ferr_prev  = 1'b0;
    logic [7:0] rx_q[$];

    uart_rx dut (
        .clk(clk),
        .rst(rst),
        .sample_trigger(sample_trigger),
        .serial_data(serial_data),
        .data(data),
        .valid(valid),
        .framing_error(framing_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) div_q <= div_q + 2'd1;
    assign sample_trigger = (div_q == 2'd3);

    always @(negedge clk) begin
        if (valid) rx_q.push_back(data);
        if (framing_error) n_ferr++;
        if (valid && framing_error) n_both++;
        if ((valid && valid_prev) || (framing_error && ferr_prev)) n_long++;
        valid_prev = valid;
        ferr_prev  = framing_error;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic line_bits(input logic b, input int n_bits);
        serial_data = b;
        repeat (n_bits * BitClks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] byte_v, input logic stop_v);
        line_bits(1'b0, 1);
        for (int i = 7; i >= 0; i--) line_bits(byte_v[i], 1);
        line_bits(stop_v, 1);
    endtask

    initial begin
        int n0;
        int f0;
        logic [7:0] rst_byte;

        rst         = 1'b1;
        serial_data = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_data", data, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_ferr", framing_error, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        line_bits(1'b1, 2);

        // Loopback-style frame 8'hA5
        n0 = rx_q.size();
        f0 = n_ferr;
        send_frame(8'hA5, 1'b1);
        line_bits(1'b1, 2);
        check("a5_count", rx_q.size() - n0, 1);
        check("a5_data", data, 8'hA5);
        check("a5_busy", busy, 1'b0);
        check("a5_ferr", n_ferr - f0, 0);

        // Directed frame 0,1,0,1,1,0,0,1,1
        n0 = rx_q.size();
        f0 = n_ferr;
        send_frame(8'h59, 1'b1);
        line_bits(1'b1, 2);
        check("h59_count", rx_q.size() - n0, 1);
        check("h59_data", data, 8'h59);
        check("h59_ferr", n_ferr - f0, 0);

        // Low stop bit, line then held low: no restart until it goes high
        n0 = rx_q.size();
        f0 = n_ferr;
        send_frame(8'hC3, 1'b0);
        line_bits(1'b0, 3);
        check("lowstop_busy", busy, 1'b0);
`ifdef UART_RX_STOP_CHECK_EN
        check("lowstop_count", rx_q.size() - n0, 0);
        check("lowstop_ferr", n_ferr - f0, 1);
        check("lowstop_data", data, 8'h59);
`else
        check("lowstop_count", rx_q.size() - n0, 1);
        check("lowstop_ferr", n_ferr - f0, 0);
        check("lowstop_data", data, 8'hC3);
`endif
        line_bits(1'b1, 2);
        check("lowstop_idle_busy", busy, 1'b0);

        // Glitch: 4 samples low
        n0 = rx_q.size();
        serial_data = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_busy_hi", busy, 1'b1);
        repeat (4) @(negedge clk);
        serial_data = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy_lo", busy, 1'b0);
        check("glitch_state", dut.state_q, IDLE);
        line_bits(1'b1, 1);
        check("glitch_count", rx_q.size() - n0, 0);

        // Back-to-back frames
        n0 = rx_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        line_bits(1'b1, 2);
        check("b2b_count", rx_q.size() - n0, 2);
        if (rx_q.size() >= n0 + 2) begin
            check("b2b_first", rx_q[n0], 8'h00);
            check("b2b_second", rx_q[n0+1], 8'hFF);
        end else begin
            check("b2b_present", rx_q.size(), n0 + 2);
        end

        // Reset after the 4th data bit
        n0 = rx_q.size();
        rst_byte = 8'hA0;
        line_bits(1'b0, 1);
        for (int i = 7; i >= 4; i--) line_bits(rst_byte[i], 1);
        rst         = 1'b1;
        serial_data = 1'b1;
        @(negedge clk);
        check("midrst_data", data, 8'h00);
        check("midrst_valid", valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ferr", framing_error, 1'b0);
        rst = 1'b0;
        line_bits(1'b1, 2);
        check("midrst_novalid", rx_q.size() - n0, 0);
        send_frame(8'h3C, 1'b1);
        line_bits(1'b1, 2);
        check("after_rst_count", rx_q.size() - n0, 1);
        check("after_rst_data", data, 8'h3C);

        check("never_both", n_both, 0);
        check("single_cycle_pulses", n_long, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
